// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: default widths, reset PC,
// FSM encoding and queue-entry sizing.
package fetch_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam int          ILEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    // Queue entry layout is {instr, pc, pc_step}.
    function automatic int entry_width(input int xlen, input int ilen);
        return ilen + 2 * xlen;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH-entry synchronous FIFO with flush and occupancy count.
// Head data reads as zero while the queue is empty.
module fetch_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify push/pop against occupancy and present the head entry
    always_comb begin
        do_pop_s  = pop && (count_q != {(AW + 1){1'b0}});
        do_push_s = push && ((count_q != FULL_CNT) || do_pop_s);
        empty     = (count_q == {(AW + 1){1'b0}});
        count     = count_q;
        if (empty) begin
            rdata = {WIDTH{1'b0}};
        end else begin
            rdata = mem_q[rd_ptr_q];
        end
    end

    // Storage, pointers and count; flush empties the queue in one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW + 1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (flush) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW + 1){1'b0}};
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + AW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1'b1);
            end
            count_q <= count_q + {{AW{1'b0}}, do_push_s} - {{AW{1'b0}}, do_pop_s};
        end
    end

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction fetch stage: PC, single-outstanding request FSM, credit-based issue
// and prefetch queue. Optional FETCH_BYPASS_EN forwards a live response to out_*.
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              ILEN     = ILEN_DEF,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_ready,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_addr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_step
);

    localparam int              EW            = entry_width(XLEN, ILEN);
    localparam int              CW            = $clog2(DEPTH) + 1;
    localparam logic [CW:0]     DEPTH_C       = (CW + 1)'(DEPTH);
    localparam logic [XLEN-1:0] PC_STEP       = XLEN'(3'd4);
    localparam logic [XLEN-1:0] PC_ALIGN_MASK = ~(XLEN'(2'b11));

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [EW-1:0]   push_data_s;
    logic [EW-1:0]   fifo_rdata_s;
    logic [CW-1:0]   fifo_count_s;
    logic            fifo_empty_s;
    logic            resp_live_s;
    logic            bypass_s;
    logic            push_s;
    logic            fifo_pop_s;
    logic            grant_s;
    logic [CW:0]     occ_after_s;

    assign imem_addr = fetch_pc_q;

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push_s),
        .wdata (push_data_s),
        .pop   (fifo_pop_s),
        .rdata (fifo_rdata_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Response acceptance, head presentation and credit-based issue decision
    always_comb begin
        resp_live_s = (state_q == ST_WAIT) && imem_ready && !redirect_valid;
`ifdef FETCH_BYPASS_EN
        bypass_s    = resp_live_s && fifo_empty_s;
`else
        bypass_s    = 1'b0;
`endif
        push_data_s = {imem_rdata, req_pc_q, req_pc_q + PC_STEP};
        if (bypass_s) begin
            out_valid                         = 1'b1;
            {out_instr, out_pc, out_pc_step}  = push_data_s;
        end else begin
            out_valid                         = !fifo_empty_s;
            {out_instr, out_pc, out_pc_step}  = fifo_rdata_s;
        end
        fifo_pop_s  = !fifo_empty_s && out_ready;
        push_s      = resp_live_s && !(bypass_s && out_ready);
        // Occupancy once this cycle's pop and push settle; must leave room for the new request.
        occ_after_s = {1'b0, fifo_count_s} - {{CW{1'b0}}, fifo_pop_s} + {{CW{1'b0}}, push_s};
        if (!rst && !redirect_valid &&
            ((state_q == ST_IDLE) || ((state_q == ST_WAIT) && imem_ready)) &&
            (occ_after_s < DEPTH_C)) begin
            imem_req = 1'b1;
        end else begin
            imem_req = 1'b0;
        end
    end

    // Next-state logic for the request FSM and the fetch/request PCs
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        grant_s    = imem_req && imem_gnt;
        if (redirect_valid) begin
            fetch_pc_d = redirect_addr & PC_ALIGN_MASK;
            case (state_q)
                ST_WAIT: state_d = imem_ready ? ST_IDLE : ST_DROP;
                ST_DROP: state_d = imem_ready ? ST_IDLE : ST_DROP;
                default: state_d = ST_IDLE;
            endcase
        end else begin
            case (state_q)
                ST_IDLE, ST_WAIT: begin
                    if (grant_s) begin
                        state_d    = ST_WAIT;
                        req_pc_d   = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + PC_STEP;
                    end else if ((state_q == ST_WAIT) && !imem_ready) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DROP: state_d = imem_ready ? ST_IDLE : ST_DROP;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM and PC registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= {XLEN{1'b0}};
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

endmodule
